// File: rtl/qif_spike_monitor.sv
// qif_spike_monitor
//   Converts a same-clock spike train from a QIF neuron into inter-spike
//   intervals (ISIs), queues them in a first-word-fall-through FIFO with a
//   valid/ready read port, and reports the spike count per fixed window.
//
//   Optional feature macro: QIF_MON_PEAK_EN
//     defined   -> v_peak is the signed maximum of v_in over the last
//                  completed window
//     undefined -> v_peak is constant 0 and v_in is ignored
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   spike_in   : spike pulse/level from the neuron (rising edge = event)
//   v_in       : signed 8-bit membrane sample
//   isi_ready  : consumer accepts the FIFO head
//   isi_data   : FIFO head (ISI in cycles), valid while isi_valid
//   isi_valid  : FIFO non-empty
//   fifo_count : FIFO occupancy
//   overflow   : sticky, set when an ISI is dropped on a full FIFO
//   rate       : spike count of the last completed window (saturating)
//   rate_stb   : one-cycle pulse when rate updates
//   v_peak     : signed peak of v_in over the last completed window
module qif_spike_monitor #(
  parameter int unsigned ISI_W      = 16,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned WIN_CYCLES = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     spike_in,
  input  logic signed [7:0]        v_in,
  input  logic                     isi_ready,
  output logic [ISI_W-1:0]         isi_data,
  output logic                     isi_valid,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [7:0]               rate,
  output logic                     rate_stb,
  output logic signed [7:0]        v_peak
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned WW = $clog2(WIN_CYCLES);
  localparam logic [ISI_W-1:0] ISI_MAX  = '1;
  localparam logic [WW-1:0]    WIN_LAST = WW'(WIN_CYCLES - 1);
  localparam logic [AW:0]      FULL_CNT = (AW + 1)'(DEPTH);

  // Spike edge detection
  logic spike_d_q;
  logic spike_ev;

  // ISI counter
  logic             armed_q, armed_d;
  logic [ISI_W-1:0] isi_cnt_q, isi_cnt_d;

  // FIFO
  logic [ISI_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ISI_W-1:0] hold_q;
  logic             push, pop, full, wr_en;

  // Rate window
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic [7:0]    spk_cnt_q, spk_cnt_d;
  logic [7:0]    rate_q, rate_d;
  logic          rate_stb_q, rate_stb_d;
  logic          win_end;
  logic [8:0]    spk_sum;
  logic [7:0]    spk_sat;

  assign spike_ev = spike_in & ~spike_d_q;

  assign isi_valid = (cnt_q != '0);
  assign full      = (cnt_q == FULL_CNT);
  assign push      = spike_ev & armed_q;
  assign pop       = isi_valid & isi_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign wr_en     = push & (~full | pop);

  assign win_end = (win_cnt_q == WIN_LAST);
  assign spk_sum = {1'b0, spk_cnt_q} + 9'(spike_ev);
  assign spk_sat = spk_sum[8] ? 8'hFF : spk_sum[7:0];

  always_comb begin
    armed_d   = armed_q;
    isi_cnt_d = isi_cnt_q;
    if (spike_ev) begin
      armed_d   = 1'b1;
      isi_cnt_d = ISI_W'(1);
    end else if (armed_q && isi_cnt_q != ISI_MAX) begin
      isi_cnt_d = isi_cnt_q + ISI_W'(1);
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
    if (push && !wr_en) ovf_d = 1'b1;
  end

  always_comb begin
    win_cnt_d  = win_end ? '0 : win_cnt_q + WW'(1);
    spk_cnt_d  = win_end ? '0 : spk_sat;
    rate_d     = win_end ? spk_sat : rate_q;
    rate_stb_d = win_end;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_d_q  <= 1'b0;
      armed_q    <= 1'b0;
      isi_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      hold_q     <= '0;
      win_cnt_q  <= '0;
      spk_cnt_q  <= '0;
      rate_q     <= '0;
      rate_stb_q <= 1'b0;
    end else begin
      spike_d_q  <= spike_in;
      armed_q    <= armed_d;
      isi_cnt_q  <= isi_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      hold_q     <= isi_data;
      win_cnt_q  <= win_cnt_d;
      spk_cnt_q  <= spk_cnt_d;
      rate_q     <= rate_d;
      rate_stb_q <= rate_stb_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= isi_cnt_q;
    end
  end

  // When empty the output keeps the last head shown (0 after reset).
  assign isi_data   = isi_valid ? mem_q[rd_ptr_q] : hold_q;
  assign fifo_count = cnt_q;
  assign overflow   = ovf_q;
  assign rate       = rate_q;
  assign rate_stb   = rate_stb_q;

`ifdef QIF_MON_PEAK_EN
  logic signed [7:0] run_max_q, run_max_d;
  logic signed [7:0] peak_q, peak_d;
  logic signed [7:0] cand;

  assign cand = (v_in > run_max_q) ? v_in : run_max_q;

  always_comb begin
    run_max_d = win_end ? 8'sh80 : cand;
    peak_d    = win_end ? cand : peak_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_max_q <= 8'sh80;
      peak_q    <= '0;
    end else begin
      run_max_q <= run_max_d;
      peak_q    <= peak_d;
    end
  end

  assign v_peak = peak_q;
`else
  // v_in is not observed in this build.
  logic unused_v_in;
  assign unused_v_in = ^v_in;
  assign v_peak      = '0;
`endif

endmodule
